// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer feeding a Uart8 tx interface.
// Presents one queued byte at a time and advances only on a fresh txDone edge.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [15:0]       sent_count,
    output logic              uart_tx_en,
    output logic              uart_tx_start,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    input  logic              uart_tx_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, empty_q, overflow_q;
    logic [15:0]       sent_q;
    logic              start_q;
    logic [7:0]        data_q;
    logic              done_q;
    state_t            state_q;

    logic push, pop, done_rise;

    assign push      = wr_en && !full_q;
    assign pop       = (state_q == IDLE) && enable && !empty_q && !uart_tx_busy;
    assign done_rise = uart_tx_done && !done_q;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Storage has no reset: pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q  <= uart_tx_done;
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
            empty_q <= (level_d == '0);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (wr_en && full_q) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            sent_q  <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        data_q  <= mem_q[rd_ptr_q];
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (!enable) begin
                        start_q <= 1'b0;
                        if (!uart_tx_busy && !done_rise) state_q <= IDLE;
                    end else if (uart_tx_busy) begin
                        start_q <= 1'b0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // With enable low the frame is abandoned, so its done edge is not counted.
                    if (!enable) begin
                        start_q <= 1'b0;
                        if (!uart_tx_busy && !done_rise) state_q <= IDLE;
                    end else if (done_rise) begin
                        sent_q  <= sent_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign sent_count    = sent_q;
    assign uart_tx_en    = enable;
    assign uart_tx_start = start_q;
    assign uart_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle vector table plus hand-written
// sequences for overflow, push/pop at full, enable drop and async reset.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full, empty, overflow;
    logic [4:0]  level;
    logic [15:0] sent_count;
    logic        uart_tx_en, uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy, uart_tx_done;

    int checks   = 0;
    int failures = 0;
    logic [7:0] cap[$];

    uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .sent_count(sent_count), .uart_tx_en(uart_tx_en), .uart_tx_start(uart_tx_start),
        .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy), .uart_tx_done(uart_tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, we;
        logic [7:0]  wd;
        logic        busy, done;
        logic        e_start;
        logic [7:0]  e_data;
        logic [4:0]  e_level;
        logic        e_empty, e_full;
        logic [15:0] e_sent;
    } vec_t;

    vec_t vecs[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        uart_tx_busy = 1'b0; uart_tx_done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    // Simple Uart8 stand-in: busy a few cycles after start, then done held for 3 cycles.
    task automatic run_frames(input int n);
        int t;
        for (int f = 0; f < n; f++) begin
            t = 0;
            while (uart_tx_start !== 1'b1 && t < 100) begin tick(); t++; end
            if (uart_tx_start !== 1'b1) begin
                checks++; failures++;
                $display("FAIL frame_start_timeout frame=%0d start=%b", f, uart_tx_start);
                return;
            end
            cap.push_back(uart_tx_data);
            tick();
            chk("start_hold", uart_tx_start, 1);
            uart_tx_busy = 1'b1;
            tick();
            chk("start_drop", uart_tx_start, 0);
            tick(); tick();
            uart_tx_busy = 1'b0; uart_tx_done = 1'b1;
            tick(); tick(); tick();
            uart_tx_done = 1'b0;
            tick();
        end
    endtask

    initial begin
        // en we wd busy done | start data level empty full sent
        vecs[0]  = '{1'b1, 1'b1, 8'd30,  1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 8'd30, 5'd0, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 8'd30, 5'd0, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd30, 5'd0, 1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'd30, 5'd0, 1'b1, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd30, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[6]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd30, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'd30, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd30, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 1'b1, 8'hA5,  1'b0, 1'b1, 1'b0, 8'd30, 5'd1, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[12] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 16'd1};
        vecs[13] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 16'd2};
        vecs[14] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 16'd2};
        vecs[15] = '{1'b1, 1'b1, 8'h3C,  1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 16'd2};
        vecs[16] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 16'd2};
        vecs[17] = '{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 16'd2};

        do_reset();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_start", uart_tx_start, 0);
        chk("rst_data", uart_tx_data, 0);

        for (int i = 0; i < 18; i++) begin
            enable = vecs[i].en; wr_en = vecs[i].we; wr_data = vecs[i].wd;
            uart_tx_busy = vecs[i].busy; uart_tx_done = vecs[i].done;
            tick();
            chk($sformatf("v%0d_start", i), uart_tx_start, vecs[i].e_start);
            chk($sformatf("v%0d_data", i),  uart_tx_data,  vecs[i].e_data);
            chk($sformatf("v%0d_level", i), level,         vecs[i].e_level);
            chk($sformatf("v%0d_empty", i), empty,         vecs[i].e_empty);
            chk($sformatf("v%0d_full", i),  full,          vecs[i].e_full);
            chk($sformatf("v%0d_sent", i),  sent_count,    vecs[i].e_sent);
        end

        // Overflow: 17 pushes with enable low, then exactly 16 frames out.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
            if (i == 15) begin
                chk("ovf_full16", full, 1);
                chk("ovf_level16", level, 16);
                chk("ovf_not_yet", overflow, 0);
            end
        end
        wr_en = 1'b0;
        chk("ovf_level17", level, 16);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_en_low", uart_tx_en, 0);
        chk("ovf_no_start", uart_tx_start, 0);
        cap.delete();
        enable = 1'b1;
        #1;
        chk("ovf_en_high", uart_tx_en, 1);
        run_frames(16);
        chk("ovf_ncap", cap.size(), 16);
        for (int i = 0; i < 16 && i < cap.size(); i++)
            chk($sformatf("ovf_byte%0d", i), cap[i], i + 1);
        for (int i = 0; i < 20; i++) tick();
        chk("ovf_no_17th", uart_tx_start, 0);
        chk("ovf_sent", sent_count, 16);
        chk("ovf_empty", empty, 1);
        chk("ovf_still_sticky", overflow, 1);

        // Full FIFO with a push and a pop on the same edge.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        chk("pp_full", full, 1);
        chk("pp_ovf0", overflow, 0);
        enable = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("pp_level15", level, 15);
        chk("pp_full0", full, 0);
        chk("pp_ovf1", overflow, 1);
        chk("pp_start", uart_tx_start, 1);
        chk("pp_data", uart_tx_data, 8'h40);

        // Enable dropped during frame 3 of 5.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        cap.delete();
        run_frames(2);
        chk("en_sent2", sent_count, 2);
        chk("en_f3_start", uart_tx_start, 1);
        chk("en_f3_data", uart_tx_data, 8'h12);
        uart_tx_busy = 1'b1;
        tick();
        enable = 1'b0;
        #1;
        chk("en_txen_now", uart_tx_en, 0);
        tick();
        uart_tx_busy = 1'b0; uart_tx_done = 1'b1;
        tick(); tick();
        uart_tx_done = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("en_sent_hold", sent_count, 2);
        chk("en_level2", level, 2);
        chk("en_start_low", uart_tx_start, 0);
        enable = 1'b1;
        run_frames(2);
        chk("en_sent4", sent_count, 4);
        chk("en_ncap", cap.size(), 4);
        if (cap.size() == 4) begin
            chk("en_byte3", cap[2], 8'h13);
            chk("en_byte4", cap[3], 8'h14);
        end
        chk("en_empty", empty, 1);

        // Asynchronous reset mid-frame with 5 bytes queued.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            tick();
        end
        wr_en = 1'b0;
        uart_tx_busy = 1'b1;
        tick();
        chk("ar_level5", level, 5);
        chk("ar_data", uart_tx_data, 8'h60);
        #2 reset = 1'b1;
        #1;
        chk("ar_level", level, 0);
        chk("ar_empty", empty, 1);
        chk("ar_full", full, 0);
        chk("ar_start", uart_tx_start, 0);
        chk("ar_data0", uart_tx_data, 0);
        chk("ar_sent", sent_count, 0);
        tick();
        reset = 1'b0;
        uart_tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("ar_post_start", uart_tx_start, 0);
        chk("ar_post_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO plus transmit sequencer. It sits directly upstream of the Uart8 transmitter and feeds its tx interface (txEn, txStart, txIn, txBusy, txDone).
- Host logic pushes bytes at clk rate. The block presents them one at a time to Uart8 and advances only when Uart8 has finished the frame.
- It replaces the ad-hoc "hold txStart high and swap txIn on a timer" driving, so back-to-back frames need no host timing knowledge.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock, same clock as Uart8.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  sequencer enable; drives uart_tx_en.
- wr_en  input  1  push wr_data when high and full is low.
- wr_data  input  8  byte to queue.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set on a push attempt while full.
- sent_count  output  16  frames completed; wraps 0xFFFF to 0.
- uart_tx_en  output  1  to Uart8 txEn.
- uart_tx_start  output  1  to Uart8 txStart.
- uart_tx_data  output  8  to Uart8 txIn.
- uart_tx_busy  input  1  from Uart8 txBusy.
- uart_tx_done  input  1  from Uart8 txDone; may stay high for many clk cycles.

Behaviour:
- Reset (async assert; deassert is synchronous to clk):
  - pointers=0, level=0, empty=1, full=0, overflow=0, sent_count=0.
  - uart_tx_start=0, uart_tx_data=0, state=IDLE, done_q=0.
- uart_tx_en = enable (combinational).
- FIFO:
  - Push accepted iff wr_en && !full, evaluated on the pre-edge state.
  - A pop in the same cycle does not free space for that push.
  - Push while full: data dropped, overflow<=1 (sticky until reset).
  - Simultaneous accepted push and pop: level unchanged.
  - Pointers wrap at DEPTH.
  - full = (level==DEPTH); empty = (level==0); both registered-consistent with level.
- done_q registers uart_tx_done every cycle; done_rise = uart_tx_done && !done_q.
- FSM:
  - IDLE: if enable && !empty && !uart_tx_busy:
    - uart_tx_data <= head byte; pop (rd_ptr++, level--);
    - uart_tx_start <= 1; go to START.
    - Latency from an accepted push into an empty FIFO to uart_tx_start high: 2 clk edges.
  - START: hold uart_tx_start=1 and uart_tx_data stable until uart_tx_busy==1, then uart_tx_start <= 0 and go to WAIT_DONE.
    - Start is held because Uart8 samples it on its slower internal tx clock.
  - WAIT_DONE: uart_tx_data held stable. On done_rise: sent_count++ and go to IDLE.
    - Dropping start in START guarantees Uart8 does not re-send the same byte.
  - A new frame may not start while uart_tx_busy is high, even in IDLE.
- Enable low mid-operation:
  - uart_tx_en falls immediately and uart_tx_start <= 0.
  - In START or WAIT_DONE: the FSM goes to IDLE once uart_tx_busy==0 and no done_rise occurs that cycle.
  - The byte is discarded: not re-queued, sent_count not incremented.
  - FIFO contents are retained; pushes are still accepted while enable is low.
- done_rise seen in IDLE or START is ignored; no count.
- A reset mid-frame flushes the FIFO and returns to IDLE regardless of uart_tx_busy.

Test Plan:
- Reset, enable=1, push 30: uart_tx_start rises 2 cycles later with uart_tx_data=30. Start drops one cycle after busy rises. After done rises, sent_count=1, empty=1.
- Push the 20-byte sequence 30,24,19,25,91,77,1,0,99,15,100,128,255,254,0,10,43,149,7,2 (DEPTH=32 build), looped into a Uart8 pair. All 20 bytes arrive at the receiver in order, sent_count=20, and no byte is duplicated while uart_tx_done is held high across multiple clk cycles.
- DEPTH=16, enable=0, push 17 bytes: full=1 after 16, level=16, overflow=1. Enable=1: exactly 16 frames go out and the 17th byte is never sent.
- Full FIFO, push and pop in the same cycle: push rejected, overflow=1, level becomes 15.
- Drop enable during frame 3 of 5: uart_tx_en=0 at once, FSM returns to IDLE after busy falls, sent_count=2, level=2. Re-enable: the remaining 2 bytes go out and sent_count=4.
- Assert reset mid-frame with 5 bytes queued: all outputs return to reset values asynchronously and the FIFO reads empty.
